// File: rtl/brg_slave_gcd_xcel_array.sv
// Multi-lane GCD slave accelerator behind a manycore endpoint.
// Word-addressed CSRs: per-lane OPA/OPB/GO/RESULT plus a global status window.
module brg_slave_gcd_xcel_array #(
  parameter int data_width_p    = 32,
  parameter int addr_width_p    = 32,
  parameter int num_lanes_p     = 4,
  parameter int blocking_read_p = 1,
  parameter int lane_width_lp   = $clog2(num_lanes_p + 1)
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic                      in_v_i,
  input  logic [addr_width_p-1:0]   in_addr_i,
  input  logic [data_width_p-1:0]   in_data_i,
  input  logic [data_width_p/8-1:0] in_mask_i,
  input  logic                      in_we_i,
  output logic                      in_yumi_o,
  output logic                      returning_v_o,
  output logic [data_width_p-1:0]   returning_data_o
);

  localparam int DW = data_width_p;
  localparam int NL = num_lanes_p;
  localparam int MW = data_width_p / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } st_e;

  st_e              st_q  [NL];
  st_e              st_d  [NL];
  logic [DW-1:0]    opa_q [NL];
  logic [DW-1:0]    opa_d [NL];
  logic [DW-1:0]    opb_q [NL];
  logic [DW-1:0]    opb_d [NL];
  logic [DW-1:0]    a_q   [NL];
  logic [DW-1:0]    a_d   [NL];
  logic [DW-1:0]    b_q   [NL];
  logic [DW-1:0]    b_d   [NL];
  logic [DW-1:0]    res_q [NL];
  logic [DW-1:0]    res_d [NL];
  logic [NL-1:0]    done_q, done_d;
  logic             rv_q, rv_d;
  logic [DW-1:0]    rdata_q, rdata_d;

  logic [1:0]               reg_sel;
  logic [lane_width_lp-1:0] lane_sel;
  logic                     hi_nz;
  logic                     is_glob;
  logic [NL-1:0]            hit;
  logic [NL-1:0]            busy;
  logic [NL-1:0]            go_w, rrd_w, w1c_w, wa_w, wb_w;
  logic [DW-1:0]            rd_val;
  logic                     stall;
  logic                     acc;

  assign reg_sel  = in_addr_i[1:0];
  assign lane_sel = in_addr_i[2 +: lane_width_lp];
  assign hi_nz    = |(in_addr_i >> (2 + lane_width_lp));
  assign is_glob  = !hi_nz && (lane_sel == lane_width_lp'(NL));

  always_comb begin
    hit  = '0;
    busy = '0;
    for (int i = 0; i < NL; i++) begin
      hit[i]  = !hi_nz && (lane_sel == lane_width_lp'(i));
      busy[i] = (st_q[i] == CALC);
    end
  end

  // Read mux and blocking-read stall
  always_comb begin
    rd_val = '0;
    stall  = 1'b0;
    for (int i = 0; i < NL; i++) begin
      if (hit[i]) begin
        case (reg_sel)
          2'd0:    rd_val = opa_q[i];
          2'd1:    rd_val = opb_q[i];
          2'd2:    rd_val = DW'(busy[i]);
          default: rd_val = busy[i] ? '1 : res_q[i];
        endcase
        stall = (blocking_read_p != 0) && !in_we_i
             && (reg_sel == 2'd3) && busy[i];
      end
    end
    if (is_glob) begin
      case (reg_sel)
        2'd0:    rd_val = DW'(done_q);
        2'd1:    rd_val = DW'(busy);
        default: rd_val = '0;
      endcase
    end
  end

  assign acc       = in_v_i && !stall && reset_n_i;
  assign in_yumi_o = acc;

  always_comb begin
    go_w  = '0;
    rrd_w = '0;
    w1c_w = '0;
    wa_w  = '0;
    wb_w  = '0;
    for (int i = 0; i < NL; i++) begin
      wa_w[i]  = acc && in_we_i && hit[i] && (reg_sel == 2'd0);
      wb_w[i]  = acc && in_we_i && hit[i] && (reg_sel == 2'd1);
      go_w[i]  = acc && in_we_i && hit[i] && (reg_sel == 2'd2);
      rrd_w[i] = acc && !in_we_i && hit[i] && (reg_sel == 2'd3);
      w1c_w[i] = acc && in_we_i && is_glob
              && (reg_sel == 2'd0) && in_data_i[i];
    end
  end

  // Lane next-state and datapath
  always_comb begin
    done_d = done_q;
    for (int i = 0; i < NL; i++) begin
      st_d[i]  = st_q[i];
      opa_d[i] = opa_q[i];
      opb_d[i] = opb_q[i];
      a_d[i]   = a_q[i];
      b_d[i]   = b_q[i];
      res_d[i] = res_q[i];
      for (int j = 0; j < MW; j++) begin
        if (wa_w[i] && in_mask_i[j])
          opa_d[i][8*j +: 8] = in_data_i[8*j +: 8];
        if (wb_w[i] && in_mask_i[j])
          opb_d[i][8*j +: 8] = in_data_i[8*j +: 8];
      end
      if (w1c_w[i]) done_d[i] = 1'b0;
      case (st_q[i])
        CALC: begin
          if (a_q[i] < b_q[i]) begin
            a_d[i] = b_q[i];
            b_d[i] = a_q[i];
          end else if (b_q[i] != '0) begin
            a_d[i] = a_q[i] - b_q[i];
          end else begin
            res_d[i]  = a_q[i];
            done_d[i] = 1'b1;
            st_d[i]   = DONE;
          end
        end
        default: begin
          if (go_w[i]) begin
            st_d[i]   = CALC;
            a_d[i]    = opa_q[i];
            b_d[i]    = opb_q[i];
            done_d[i] = 1'b0;
          end else if (st_q[i] == DONE && (rrd_w[i] || w1c_w[i])) begin
            st_d[i]   = IDLE;
            done_d[i] = 1'b0;
          end
        end
      endcase
    end
  end

  assign rv_d    = acc;
  assign rdata_d = acc ? (in_we_i ? '0 : rd_val) : rdata_q;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < NL; i++) begin
        st_q[i]  <= IDLE;
        opa_q[i] <= '0;
        opb_q[i] <= '0;
        a_q[i]   <= '0;
        b_q[i]   <= '0;
        res_q[i] <= '0;
      end
      done_q  <= '0;
      rv_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      for (int i = 0; i < NL; i++) begin
        st_q[i]  <= st_d[i];
        opa_q[i] <= opa_d[i];
        opb_q[i] <= opb_d[i];
        a_q[i]   <= a_d[i];
        b_q[i]   <= b_d[i];
        res_q[i] <= res_d[i];
      end
      done_q  <= done_d;
      rv_q    <= rv_d;
      rdata_q <= rdata_d;
    end
  end

  assign returning_v_o    = rv_q;
  assign returning_data_o = rdata_q;

endmodule

// File: tb/tb_brg_slave_gcd_xcel_array.sv
// Directed bench for brg_slave_gcd_xcel_array.
// Drives a blocking and a non-blocking instance from shared request lines.
module tb_brg_slave_gcd_xcel_array;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_v = 1'b0;
  logic        in_we = 1'b0;
  logic [31:0] in_addr = '0;
  logic [31:0] in_data = '0;
  logic [3:0]  in_mask = '0;
  logic        y_b, y_nb, rv_b, rv_nb;
  logic [31:0] rd_b, rd_nb;
  bit          sel = 1'b0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  brg_slave_gcd_xcel_array #(.blocking_read_p(1)) u_b (
    .clk_i(clk), .reset_n_i(rst_n), .in_v_i(in_v),
    .in_addr_i(in_addr), .in_data_i(in_data), .in_mask_i(in_mask),
    .in_we_i(in_we), .in_yumi_o(y_b), .returning_v_o(rv_b),
    .returning_data_o(rd_b)
  );

  brg_slave_gcd_xcel_array #(.blocking_read_p(0)) u_nb (
    .clk_i(clk), .reset_n_i(rst_n), .in_v_i(in_v),
    .in_addr_i(in_addr), .in_data_i(in_data), .in_mask_i(in_mask),
    .in_we_i(in_we), .in_yumi_o(y_nb), .returning_v_o(rv_nb),
    .returning_data_o(rd_nb)
  );

  wire        yumi = sel ? y_nb : y_b;
  wire        rv   = sel ? rv_nb : rv_b;
  wire [31:0] rdat = sel ? rd_nb : rd_b;

  typedef struct {
    int          lane;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          steps;
  } vec_t;

  vec_t vecs [6];

  function automatic logic [31:0] ad(input int lane, input int r);
    return 32'((lane << 2) | r);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic xact(input logic we, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [3:0] m,
                      output logic [31:0] rd, output int stalls);
    bit ok;
    ok = 1'b0;
    stalls = 0;
    in_v = 1'b1; in_we = we; in_addr = addr; in_data = wd; in_mask = m;
    while (!ok && stalls < 3000) begin
      @(negedge clk);
      if (yumi) ok = 1'b1;
      @(posedge clk); #1;
      if (!ok) stalls++;
    end
    in_v = 1'b0;
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    else chk("resp_valid", 32'(rv), 32'd1);
    rd = rdat;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] wd);
    logic [31:0] rd;
    int s;
    xact(1'b1, addr, wd, 4'hf, rd, s);
    chk("wr_resp_data", rd, 32'd0);
  endtask

  task automatic rdc(input string nm, input logic [31:0] addr,
                     input logic [31:0] exp);
    logic [31:0] rd;
    int s;
    xact(1'b0, addr, 32'd0, 4'hf, rd, s);
    chk(nm, rd, exp);
  endtask

  task automatic poll(input int lane);
    logic [31:0] rd;
    int s, n;
    n = 0;
    rd = 32'd1;
    while (rd != 32'd0 && n < 2000) begin
      xact(1'b0, ad(lane, 2), 32'd0, 4'hf, rd, s);
      n++;
    end
    if (rd != 32'd0) chk("poll_timeout", rd, 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_v = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rv", 32'(rv_b | rv_nb), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic check_all_zero(input string nm);
    for (int l = 0; l <= 4; l++)
      for (int r = 0; r < 4; r++)
        rdc(nm, ad(l, r), 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    int s;

    vecs[0] = '{1, 32'd48, 32'd18, 32'd6, 9};
    vecs[1] = '{0, 32'd0,  32'd0,  32'd0, 1};
    vecs[2] = '{2, 32'd0,  32'd7,  32'd7, 2};
    vecs[3] = '{3, 32'd7,  32'd0,  32'd7, 1};
    vecs[4] = '{0, 32'd15, 32'd5,  32'd5, 5};
    vecs[5] = '{1, 32'd12, 32'd8,  32'd4, 6};

    do_reset();
    chk("idle_rv", 32'(rv_b), 32'd0);
    check_all_zero("reset_csr");

    // Lane0 poll flow
    wr(ad(0, 0), 32'd15);
    wr(ad(0, 1), 32'd5);
    wr(ad(0, 2), 32'd0);
    poll(0);
    rdc("done_before", ad(4, 0), 32'h1);
    rdc("lane0_res", ad(0, 3), 32'd5);
    rdc("done_after", ad(4, 0), 32'h0);

    // Table: blocking RESULT right after GO, stall count = step count
    foreach (vecs[k]) begin
      wr(ad(vecs[k].lane, 0), vecs[k].a);
      wr(ad(vecs[k].lane, 1), vecs[k].b);
      wr(ad(vecs[k].lane, 2), 32'd0);
      xact(1'b0, ad(vecs[k].lane, 3), 32'd0, 4'hf, rd, s);
      chk($sformatf("vec%0d_res", k), rd, vecs[k].res);
      chk($sformatf("vec%0d_steps", k), 32'(s), 32'(vecs[k].steps));
      rdc($sformatf("vec%0d_done", k), ad(4, 0), 32'h0);
    end

    // Busy-lane interference on lane3
    wr(ad(3, 0), 32'd30);
    wr(ad(3, 1), 32'd12);
    wr(ad(3, 2), 32'd0);
    wr(ad(3, 0), 32'd99);
    wr(ad(3, 2), 32'd0);
    xact(1'b0, ad(3, 3), 32'd0, 4'hf, rd, s);
    chk("intf_res", rd, 32'd6);
    chk("intf_stall", 32'(s), 32'd5);
    rdc("intf_opa", ad(3, 0), 32'd99);
    wr(ad(3, 2), 32'd0);
    xact(1'b0, ad(3, 3), 32'd0, 4'hf, rd, s);
    chk("intf_res2", rd, 32'd3);
    chk("intf_steps2", 32'(s), 32'd15);

    // W1C of done flag, result retained
    wr(ad(0, 0), 32'd7);
    wr(ad(0, 1), 32'd0);
    wr(ad(0, 2), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    rdc("w1c_done_set", ad(4, 0), 32'h1);
    wr(ad(4, 0), 32'h1);
    rdc("w1c_done_clr", ad(4, 0), 32'h0);
    rdc("w1c_busy", ad(0, 2), 32'd0);
    rdc("w1c_res_kept", ad(0, 3), 32'd7);

    // Byte-masked write
    wr(ad(2, 1), 32'hffff_ffff);
    xact(1'b1, ad(2, 1), 32'h0000_ab00, 4'b0010, rd, s);
    rdc("mask_opb", ad(2, 1), 32'hffff_abff);

    // Out-of-range: high address bits and lane beyond global
    wr(ad(0, 0), 32'h1234);
    wr(32'h0000_0020, 32'h5555);
    rdc("oor_wr_dropped", ad(0, 0), 32'h1234);
    rdc("oor_hi_rd", 32'h0000_0020, 32'd0);
    rdc("oor_lane5_rd", ad(5, 0), 32'd0);
    rdc("oor_far_rd", 32'h8000_0000, 32'd0);
    rdc("glob_reg2", ad(4, 2), 32'd0);

    // Non-blocking instance
    do_reset();
    sel = 1'b1;
    wr(ad(2, 0), 32'd1000);
    wr(ad(2, 1), 32'd1);
    wr(ad(2, 2), 32'd0);
    xact(1'b0, ad(2, 3), 32'd0, 4'hf, rd, s);
    chk("nb_early_res", rd, 32'hffff_ffff);
    chk("nb_no_stall", 32'(s), 32'd0);
    rdc("nb_busy", ad(2, 2), 32'd1);
    poll(2);
    rdc("nb_done", ad(4, 0), 32'h4);
    rdc("nb_res", ad(2, 3), 32'd1);
    sel = 1'b0;

    // Reset mid-CALC
    do_reset();
    wr(ad(1, 0), 32'd1000);
    wr(ad(1, 1), 32'd1);
    wr(ad(1, 2), 32'd0);
    rdc("busy_mask", ad(4, 1), 32'h2);
    repeat (3) @(posedge clk);
    #2;
    in_v = 1'b1; in_we = 1'b0; in_addr = ad(1, 0);
    rst_n = 1'b0;
    #1;
    chk("midrst_yumi", 32'(y_b), 32'd0);
    chk("midrst_rv", 32'(rv_b), 32'd0);
    chk("midrst_data", rd_b, 32'd0);
    in_v = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("postrst_rv", 32'(rv_b), 32'd0);
    check_all_zero("postrst_csr");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
